t02_wb_multi_manager: RTL and testbench

Parametrised Wishbone classic-cycle manager that lets NUM_CH on-chip requesters share the single Wishbone port of the team_02 macro. Typical requesters are the CPU instruction fetch and data ports, plus a debug/DMA channel. Requests are arbitrated round-robin, issued one at a time as single Wishbone read or write cycles, and completed with a registered per-channel done pulse. The block sits between t02_top and the macro's ADR_O/DAT_O/SEL_O/WE_O/STB_O/CYC_O/DAT_I/ACK_I pins and supersedes the single-channel manager.

---
 rtl/t02_wb_pkg.sv | 8 +
 rtl/t02_rr_arbiter.sv | 28 ++
 rtl/t02_wb_multi_manager.sv | 102 ++++++++++
 tb/tb_t02_wb_multi_manager.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/t02_wb_pkg.sv
// t02_wb_pkg: shared FSM state type, default timeout and byte-select width helper for the Wishbone manager.
package t02_wb_pkg;
  typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;
  localparam int DEF_TIMEOUT_CYCLES = 255;
  function automatic int sel_w(input int data_w);
    return data_w / 8;
  endfunction
endpackage

// File: rtl/t02_rr_arbiter.sv
// t02_rr_arbiter: combinational round-robin pick of the first requester after the last-grant pointer.
module t02_rr_arbiter #(
  parameter int N = 2,
  localparam int IW = N > 1 ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          valid
);
  logic [IW-1:0] c;
  always_comb begin
    gnt = '0;
    idx = '0;
    valid = 1'b0;
    c = '0;
    for (int i = 1; i <= N; i++) begin
      c = IW'((int'(ptr) + i) % N);
      if (en && !valid && req[c]) begin
        valid = 1'b1;
        idx = c;
        gnt[c] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/t02_wb_multi_manager.sv
// t02_wb_multi_manager: round-robin multi-channel Wishbone classic single-cycle manager.
// Optional ACK timeout is built only when T02_WB_TIMEOUT_EN is defined.
module t02_wb_multi_manager
  import t02_wb_pkg::*;
#(
  parameter int NUM_CH         = 2,
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               en,
  input  logic [NUM_CH-1:0]                  rd_i,
  input  logic [NUM_CH-1:0]                  wr_i,
  input  logic [NUM_CH*ADDR_W-1:0]           adr_i,
  input  logic [NUM_CH*DATA_W-1:0]           wdat_i,
  input  logic [NUM_CH*sel_w(DATA_W)-1:0]    sel_i,
  output logic [DATA_W-1:0]                  rdat_o,
  output logic [NUM_CH-1:0]                  done_o,
  output logic [NUM_CH-1:0]                  err_o,
  output logic [NUM_CH-1:0]                  busy_o,
  output logic [ADDR_W-1:0]                  ADR_O,
  output logic [DATA_W-1:0]                  DAT_O,
  output logic [sel_w(DATA_W)-1:0]           SEL_O,
  output logic                               WE_O,
  output logic                               STB_O,
  output logic                               CYC_O,
  input  logic [DATA_W-1:0]                  DAT_I,
  input  logic                               ACK_I
);
  localparam int SW = sel_w(DATA_W);
  localparam int IW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  state_t state, nxt;
  logic [IW-1:0] ptr, gidx;
  logic [NUM_CH-1:0] gnt, gnt_q;
  logic grant, fin, to;
  t02_rr_arbiter #(.N(NUM_CH)) u_arb (
    .req(rd_i | wr_i),
    .ptr(ptr),
    .en(en && state == IDLE),
    .gnt(gnt),
    .idx(gidx),
    .valid(grant)
  );
  // a timeout only ends the cycle when no ACK arrives in the same cycle
  assign fin = state == BUS && (ACK_I || to);
  assign busy_o = (rd_i | wr_i) & ~done_o;
  always_comb begin
    nxt = state == IDLE ? (grant ? BUS : IDLE) : state == BUS ? (fin ? DONE : BUS) : IDLE;
    CYC_O = state == BUS;
    STB_O = state == BUS;
  end
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= nxt;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= IW'(NUM_CH - 1);
      gnt_q <= '0;
      ADR_O <= '0;
      DAT_O <= '0;
      SEL_O <= '0;
      WE_O <= 1'b0;
      rdat_o <= '0;
      done_o <= '0;
    end else begin
      done_o <= fin ? gnt_q : '0;
      if (grant) begin
        ptr <= gidx;
        gnt_q <= gnt;
        ADR_O <= adr_i[int'(gidx)*ADDR_W +: ADDR_W];
        DAT_O <= wdat_i[int'(gidx)*DATA_W +: DATA_W];
        SEL_O <= sel_i[int'(gidx)*SW +: SW];
        WE_O <= wr_i[gidx];
      end
      if (fin) begin
        WE_O <= 1'b0;
        if (!ACK_I) rdat_o <= '0;
        else if (!WE_O) rdat_o <= DAT_I;
      end
    end
  end
`ifdef T02_WB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1) < 8 ? 8 : $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt;
  assign to = cnt == CW'(TIMEOUT_CYCLES);
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      err_o <= '0;
    end else begin
      cnt <= state == BUS ? cnt + 1'b1 : '0;
      err_o <= (fin && !ACK_I) ? gnt_q : '0;
    end
  end
`else
  assign to = 1'b0;
  assign err_o = '0;
`endif
endmodule

// File: tb/tb_t02_wb_multi_manager.sv
// tb_t02_wb_multi_manager: scoreboard bench for the multi-channel Wishbone manager.
module tb_t02_wb_multi_manager;
  logic clk = 0, rst = 1, en = 1;
  logic [1:0] rd_i = 0, wr_i = 0, done_o, err_o, busy_o;
  logic [63:0] adr_i = 0, wdat_i = 0;
  logic [7:0] sel_i = 0;
  logic [31:0] rdat_o, ADR_O, DAT_O, DAT_I;
  logic [3:0] SEL_O;
  logic WE_O, STB_O, CYC_O, ACK_I;
  typedef struct {logic [1:0] done; logic [31:0] rdat; logic err; int gap;} exp_t;
  exp_t sb[$];
  int total = 0, bad = 0, cyc = 0, last = 0, wcnt = 0, ack_dly = 0, s, d;
  int left[2];
  logic no_ack = 0, stray_ack = 0, chk_bus = 0, exp_we;
  logic [31:0] data_val = 0, exp_adr, exp_dat, exp_rdat = 0;
  logic [3:0] exp_sel;

  t02_wb_multi_manager #(.NUM_CH(2), .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst), .en(en), .rd_i(rd_i), .wr_i(wr_i), .adr_i(adr_i), .wdat_i(wdat_i),
    .sel_i(sel_i), .rdat_o(rdat_o), .done_o(done_o), .err_o(err_o), .busy_o(busy_o),
    .ADR_O(ADR_O), .DAT_O(DAT_O), .SEL_O(SEL_O), .WE_O(WE_O), .STB_O(STB_O), .CYC_O(CYC_O),
    .DAT_I(DAT_I), .ACK_I(ACK_I)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // slave: acks ack_dly cycles after STB rises unless no_ack
  initial begin
    ACK_I = 0;
    DAT_I = 0;
    forever begin
      @(negedge clk);
      DAT_I = data_val;
      ACK_I = (STB_O && wcnt == ack_dly && !no_ack) || stray_ack;
      wcnt = STB_O ? wcnt + 1 : 0;
    end
  end

  // scoreboard consumer
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (done_o !== 2'b00) begin
        if (sb.size() == 0) chk("extra_done", done_o, 0);
        else begin
          e = sb.pop_front();
          chk("done_ch", done_o, e.done);
          chk("rdat", rdat_o, e.rdat);
          chk("err", err_o, e.err);
          if (e.gap != 0) chk("gap", cyc - last, e.gap);
        end
        last = cyc;
      end else if (err_o !== 2'b00) chk("stray_err", err_o, 0);
    end
  end

  task automatic run(input int n, output int stb_at, output int done_at);
    int seen = 0;
    stb_at = -1;
    done_at = -1;
    for (int i = 1; i <= 200 && seen < n; i++) begin
      @(negedge clk);
      if (STB_O && stb_at < 0) stb_at = i;
      if (STB_O && chk_bus) begin
        chk("adr", ADR_O, exp_adr);
        chk("dat", DAT_O, exp_dat);
        chk("sel", SEL_O, exp_sel);
        chk("we", WE_O, exp_we);
      end
      for (int c = 0; c < 2; c++)
        if (done_o[c]) begin
          seen++;
          if (done_at < 0) done_at = i;
          if (left[c] > 0) left[c]--;
          if (left[c] == 0) begin
            rd_i[c] = 0;
            wr_i[c] = 0;
          end
        end
    end
    if (seen < n) chk("run_budget", seen, n);
  endtask

  task automatic wait_stb();
    for (int i = 0; i < 50 && !STB_O; i++) @(negedge clk);
    chk("stb_seen", STB_O, 1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_cyc", CYC_O, 0);
    chk("rst_done", done_o, 0);
    rst = 0;
    @(negedge clk);
    chk("rst_stb", STB_O, 0);
    chk("rst_we", WE_O, 0);
    chk("rst_adr", ADR_O, 0);
    chk("rst_rdat", rdat_o, 0);
    chk("rst_sel", SEL_O, 0);
    chk("rst_err", err_o, 0);
    chk("rst_busy", busy_o, 0);
    // single read, ACK two cycles after STB
    data_val = 32'hA5A5_1234;
    ack_dly = 2;
    exp_rdat = data_val;
    sb.push_back('{2'b01, exp_rdat, 1'b0, 0});
    adr_i[31:0] = 32'h3000_0010;
    exp_adr = 32'h3000_0010; exp_dat = 0; exp_sel = 0; exp_we = 0; chk_bus = 1;
    left[0] = 1;
    rd_i = 2'b01;
    run(1, s, d);
    chk("rd_stb_at", s, 1);
    chk("rd_done_at", d, 4);
    // write on ch1, rdat must hold the earlier read
    @(negedge clk);
    data_val = 32'hDEAD_BEEF;
    ack_dly = 1;
    sb.push_back('{2'b10, exp_rdat, 1'b0, 0});
    adr_i[63:32] = 32'h3000_0020;
    wdat_i[63:32] = 32'hCAFE_F00D;
    sel_i[7:4] = 4'h3;
    exp_adr = 32'h3000_0020; exp_dat = 32'hCAFE_F00D; exp_sel = 4'h3; exp_we = 1;
    left[1] = 1;
    wr_i = 2'b10;
    run(1, s, d);
    chk("wr_done_at", d, 3);
    chk_bus = 0;
    // contention, immediate ACK
    @(negedge clk);
    data_val = 32'h1111_2222;
    ack_dly = 0;
    exp_rdat = data_val;
    sb.push_back('{2'b01, exp_rdat, 1'b0, 0});
    sb.push_back('{2'b10, exp_rdat, 1'b0, 3});
    sb.push_back('{2'b01, exp_rdat, 1'b0, 3});
    sb.push_back('{2'b10, exp_rdat, 1'b0, 3});
    left[0] = 2;
    left[1] = 2;
    rd_i = 2'b11;
    run(4, s, d);
    // ACK outside BUS is ignored
    @(negedge clk);
    stray_ack = 1;
    repeat (3) @(negedge clk);
    chk("stray_cyc", CYC_O, 0);
    stray_ack = 0;
    // en gating
    en = 0;
    data_val = 32'h0BAD_F00D;
    exp_rdat = data_val;
    left[0] = 1;
    rd_i = 2'b01;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("en_cyc", CYC_O, 0);
      chk("en_busy", busy_o, 2'b01);
    end
    sb.push_back('{2'b01, exp_rdat, 1'b0, 0});
    en = 1;
    @(posedge clk);
    #1;
    chk("en_stb", STB_O, 1);
    run(1, s, d);
    // reset mid-BUS aborts without done, then the request is re-issued
    @(negedge clk);
    no_ack = 1;
    left[0] = 1;
    rd_i = 2'b01;
    wait_stb();
    rst = 1;
    @(posedge clk);
    #1;
    chk("rstb_cyc", CYC_O, 0);
    chk("rstb_stb", STB_O, 0);
    chk("rstb_done", done_o, 0);
    @(negedge clk);
    rst = 0;
    no_ack = 0;
    data_val = 32'h7777_0001;
    exp_rdat = data_val;
    sb.push_back('{2'b01, exp_rdat, 1'b0, 0});
    run(1, s, d);
    chk("rstb_reissue", d, 2);
`ifdef T02_WB_TIMEOUT_EN
    @(negedge clk);
    no_ack = 1;
    exp_rdat = 0;
    sb.push_back('{2'b01, 32'h0, 1'b1, 0});
    left[0] = 1;
    rd_i = 2'b01;
    run(1, s, d);
    chk("to_lat", d - s, 9);
    chk("to_cyc", CYC_O, 0);
    no_ack = 0;
`endif
    repeat (3) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
